// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file write-port arbiter: pipeline vs. 2-entry secondary FIFO
// Pipeline has priority until it has won STARVE_MAX grants back-to-back over a waiting secondary.
module wb_arbiter #(
  parameter int STARVE_MAX = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       p_en,
  input  logic [2:0] p_reg,
  input  logic [9:0] p_data,
  input  logic       s_valid,
  input  logic [2:0] s_reg,
  input  logic [9:0] s_data,
  output logic       s_ready,
  output logic       stall,
  output logic       wr_en,
  output logic [2:0] wr_reg,
  output logic [9:0] wr_data,
  output logic [1:0] q_count
);

  logic [12:0] entry0_q, entry1_q;
  logic        head_q;
  logic [1:0]  cnt_q, cnt_d;
  logic [2:0]  sc_q, sc_d;
  logic        wr_en_q;
  logic [2:0]  wr_reg_q;
  logic [9:0]  wr_data_q;

  logic        push, grant_p, grant_s, wr_idx;
  logic [12:0] head_entry;

  assign s_ready    = (cnt_q != 2'd2);
  assign stall      = (sc_q == 3'(STARVE_MAX)) && (cnt_q != 2'd0);
  assign q_count    = cnt_q;
  assign wr_en      = wr_en_q;
  assign wr_reg     = wr_reg_q;
  assign wr_data    = wr_data_q;
  assign head_entry = head_q ? entry1_q : entry0_q;
  // Tail slot is the head slot when empty, the other slot when one entry is held.
  assign wr_idx     = head_q ^ cnt_q[0];

  always_comb begin
    push    = s_valid && s_ready;
    grant_p = p_en && !stall;
    grant_s = !grant_p && (cnt_q != 2'd0);
    cnt_d   = cnt_q + {1'b0, push} - {1'b0, grant_s};
    sc_d    = sc_q;
    if (grant_s || (cnt_q == 2'd0)) begin
      sc_d = 3'd0;
    end else if (grant_p) begin
      sc_d = sc_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry0_q  <= '0;
      entry1_q  <= '0;
      head_q    <= 1'b0;
      cnt_q     <= 2'd0;
      sc_q      <= 3'd0;
      wr_en_q   <= 1'b0;
      wr_reg_q  <= 3'd0;
      wr_data_q <= 10'd0;
    end else begin
      if (push && !wr_idx) entry0_q <= {s_reg, s_data};
      if (push &&  wr_idx) entry1_q <= {s_reg, s_data};
      if (grant_s) head_q <= ~head_q;
      cnt_q   <= cnt_d;
      sc_q    <= sc_d;
      wr_en_q <= grant_p || grant_s;
      if (grant_p) begin
        wr_reg_q  <= p_reg;
        wr_data_q <= p_data;
      end else if (grant_s) begin
        wr_reg_q  <= head_entry[12:10];
        wr_data_q <= head_entry[9:0];
      end
    end
  end

endmodule
